// File: rtl/glyph_pixel_reader_if.sv
// Pixel stream from the glyph reader to the TFT write path: one coloured pixel per
// handshake, tagged with its glyph coordinates and row/glyph end markers.
interface glyph_pixel_reader_if #(
  parameter int COLOR_W = 16,
  parameter int X_W     = 3,
  parameter int Y_W     = 4
);
  logic               pix_valid;
  logic               pix_ready;
  logic [COLOR_W-1:0] pix_data;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic               pix_eol;
  logic               pix_eof;

  modport master (
    output pix_valid,
    input  pix_ready,
    output pix_data,
    output pix_x,
    output pix_y,
    output pix_eol,
    output pix_eof
  );

  modport slave (
    input  pix_valid,
    output pix_ready,
    input  pix_data,
    input  pix_x,
    input  pix_y,
    input  pix_eol,
    input  pix_eof
  );
endinterface

// File: rtl/glyph_pixel_reader.sv
// Walks a 1-bit glyph ROM in row-major order and streams FG/BG colour pixels over a
// valid/ready handshake at full rate, steering the ROM address one pixel ahead.
module glyph_pixel_reader #(
  parameter int              GLYPH_W  = 8,
  parameter int              GLYPH_H  = 16,
  parameter int              ADDR_W   = 7,
  parameter int              COLOR_W  = 16,
  parameter logic [COLOR_W-1:0] FG_COLOR = 16'hFFFF,
  parameter logic [COLOR_W-1:0] BG_COLOR = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  input  logic              rom_q,
  glyph_pixel_reader_if.master pix
);

  localparam int X_W = $clog2(GLYPH_W);
  localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(GLYPH_W * GLYPH_H - 1);
  localparam logic [X_W-1:0]    LAST_X = X_W'(GLYPH_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic              done_q, done_d;

  logic in_stream;
  logic at_last;
  logic accept;

  assign in_stream = (state_q == STREAM);
  assign at_last   = (p_q == LAST_P);
  assign accept    = in_stream && pix.pix_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRIME;
          p_d     = '0;
        end
      end
      PRIME: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (accept) begin
          if (at_last) begin
            state_d = IDLE;
            p_d     = '0;
            done_d  = 1'b1;
          end else begin
            p_d = p_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        p_d     = '0;
      end
    endcase
  end

  // Look ahead on an accepting edge so the registered ROM output lines up with p
  // on the following cycle; while stalled the address stays on p.
  assign rom_address = (accept && !at_last) ? (p_q + ADDR_W'(1)) : p_q;

  assign busy = (state_q != IDLE);
  assign done = done_q;

  assign pix.pix_valid = in_stream;
  assign pix.pix_data  = rom_q ? FG_COLOR : BG_COLOR;
  assign pix.pix_x     = p_q[X_W-1:0];
  assign pix.pix_y     = p_q[ADDR_W-1:X_W];
  assign pix.pix_eol   = in_stream && (p_q[X_W-1:0] == LAST_X);
  assign pix.pix_eof   = in_stream && at_last;

endmodule

// File: tb/tb_glyph_pixel_reader.sv
// Directed bench for glyph_pixel_reader using a "7" glyph ROM model with 1-cycle latency.
module tb_glyph_pixel_reader;

  logic       clock;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [6:0] rom_address;
  logic       rom_q;

  int checks   = 0;
  int failures = 0;

  glyph_pixel_reader_if #(.COLOR_W(16), .X_W(3), .Y_W(4)) pix_if ();

  glyph_pixel_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix         (pix_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit glyph_bit(input int a);
    return a inside {[25:30], 33, 38, 45, 53, 60, 68, 75, 83, 91, 99, 107};
  endfunction

  function automatic logic [15:0] exp_color(input int a);
    return glyph_bit(a) ? 16'hFFFF : 16'h0000;
  endfunction

  always @(posedge clock) rom_q <= glyph_bit(int'(rom_address));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one glyph and follows it to done. mode 1 randomises pix_ready; stall_p
  // holds ready low for 10 cycles at that pixel; start_p pulses start mid-glyph;
  // abort_p asserts reset at that pixel and abandons the glyph.
  task automatic run_glyph(input int mode, input int stall_p, input int start_p, input int abort_p);
    int  k = 0;
    int  cyc = 0;
    int  stall_left = 10;
    bit  start_sent = 0;
    bit  aborted = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    #1;
    chk("prime_busy", busy, 1);
    chk("prime_valid", pix_if.pix_valid, 0);
    chk("prime_addr", rom_address, 0);
    while (k < 128 && cyc < 2000 && !aborted) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (k == abort_p) begin
        reset = 1'b1;
        pix_if.pix_ready = 1'b1;
        aborted = 1;
      end else begin
        if (k == start_p && !start_sent) begin
          start = 1'b1;
          start_sent = 1;
        end
        if (k == stall_p && stall_left > 0) begin
          pix_if.pix_ready = 1'b0;
          stall_left--;
        end else if (mode == 1) begin
          pix_if.pix_ready = 1'($urandom_range(0, 1));
        end else begin
          pix_if.pix_ready = 1'b1;
        end
        #1;
        chk("valid", pix_if.pix_valid, 1);
        chk("done_mid", done, 0);
        chk("data", pix_if.pix_data, exp_color(k));
        chk("x", pix_if.pix_x, k % 8);
        chk("y", pix_if.pix_y, k / 8);
        chk("eol", pix_if.pix_eol, (k % 8) == 7);
        chk("eof", pix_if.pix_eof, k == 127);
        if (pix_if.pix_ready) begin
          chk("addr_next", rom_address, (k == 127) ? 127 : k + 1);
          $display("pixel p=%0d x=%0d y=%0d data=%04h", k, pix_if.pix_x, pix_if.pix_y, pix_if.pix_data);
          k++;
        end else begin
          chk("addr_stall", rom_address, k);
        end
      end
    end
    if (cyc >= 2000) chk("glyph_timeout", cyc, 0);
    @(negedge clock);
    start = 1'b0;
    if (aborted) begin
      reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_valid", pix_if.pix_valid, 0);
      chk("abort_done", done, 0);
      $display("glyph aborted by reset at p=%0d", abort_p);
      @(negedge clock);
      #1;
      chk("abort_done2", done, 0);
    end else begin
      #1;
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_valid", pix_if.pix_valid, 0);
      chk("done_eof", pix_if.pix_eof, 0);
      @(negedge clock);
      #1;
      chk("done_single", done, 0);
      chk("no_requeue", busy, 0);
      $display("glyph complete cycles=%0d", cyc);
    end
  endtask

  initial begin
    int k;
    int cyc;
    int gap;
    bit seen_valid;
    reset = 1'b1;
    start = 1'b0;
    pix_if.pix_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", pix_if.pix_valid, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_x", pix_if.pix_x, 0);
    chk("rst_y", pix_if.pix_y, 0);
    chk("rst_eol", pix_if.pix_eol, 0);
    chk("rst_eof", pix_if.pix_eof, 0);
    reset = 1'b0;

    run_glyph(0, -1, -1, -1);    // full rate
    run_glyph(1, -1, -1, -1);    // random back-pressure
    run_glyph(0, 33, -1, -1);    // 10-cycle stall on p=33
    run_glyph(0, -1, 60, -1);    // start while busy
    run_glyph(0, -1, -1, 70);    // reset mid-glyph
    run_glyph(0, -1, -1, -1);    // replay from p=0

    // start held high: two glyphs back to back with a 2-cycle gap
    @(negedge clock);
    start = 1'b1;
    pix_if.pix_ready = 1'b1;
    k = 0;
    cyc = 0;
    gap = 0;
    seen_valid = 0;
    while (k < 256 && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      #1;
      if (pix_if.pix_valid) begin
        seen_valid = 1;
        chk("b2b_data", pix_if.pix_data, exp_color(k % 128));
        chk("b2b_x", pix_if.pix_x, (k % 128) % 8);
        k++;
      end else if (seen_valid) begin
        gap++;
      end
    end
    if (cyc >= 1000) chk("b2b_timeout", cyc, 0);
    chk("b2b_gap", gap, 2);
    $display("back-to-back glyphs pixels=%0d gap=%0d", k, gap);
    @(negedge clock);
    start = 1'b0;
    #1;
    chk("b2b_done", done, 1);
    @(negedge clock);
    #1;
    chk("b2b_stop", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
